// File: rtl/mema_chunk_scheduler.sv
// rtl/mema_chunk_scheduler.sv - row-by-row matrix-A read sequencer with per-lane chunk handshakes
//
// Steps the memA read address over rows 0..row_count-1. For every row it waits
// for the memory read latency, then offers each lane chunk indices
// 1..no_of_multiples[lane] under a valid/ready handshake. It moves to the next
// row only once every lane has taken all of its chunks.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              one-cycle pulse, accepted only while idle
//   row_count          rows to process, sampled on start, clamped to memory_A_height+1
//   no_of_multiples    per-lane chunk counts (lane L at [(L+1)*W-1 -: W]), sampled on start
//   I_am_ready         per-lane ready
//   memA_read_address  registered A read address
//   chunk_index        per-lane current chunk index, 1-based
//   chunk_valid        per-lane chunk valid
//   row_done           one-cycle pulse after all lanes finish a row
//   busy               high while a pass is in progress
//   done               one-cycle pulse at the end of a pass
module mema_chunk_scheduler #(
    parameter int no_of_row_by_vector_modules  = 4,
    parameter int memory_A_height              = 2000,
    parameter int address_width                = $clog2(memory_A_height) + 1,
    parameter int multiples_memory_value_width = 32,
    parameter int read_latency                 = 2
) (
    input  logic                                                           clk,
    input  logic                                                           rst,
    input  logic                                                           start,
    input  logic [address_width:0]                                         row_count,
    input  logic [multiples_memory_value_width*no_of_row_by_vector_modules-1:0] no_of_multiples,
    input  logic [no_of_row_by_vector_modules-1:0]                         I_am_ready,
    output logic [address_width-1:0]                                       memA_read_address,
    output logic [multiples_memory_value_width*no_of_row_by_vector_modules-1:0] chunk_index,
    output logic [no_of_row_by_vector_modules-1:0]                         chunk_valid,
    output logic                                                           row_done,
    output logic                                                           busy,
    output logic                                                           done
);

    localparam int N      = no_of_row_by_vector_modules;
    localparam int W      = multiples_memory_value_width;
    localparam int WAIT_W = (read_latency > 1) ? $clog2(read_latency) : 1;

    localparam logic [WAIT_W-1:0]      WAIT_LAST = WAIT_W'(read_latency - 1);
    localparam logic [address_width:0] ROWS_MAX  = (address_width + 1)'(memory_A_height + 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_ISSUE   = 3'd2;
    localparam logic [2:0] ST_ROW_END = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]               r_state;
    logic [address_width-1:0] r_addr;
    logic [address_width:0]   r_rows;
    logic [N-1:0][W-1:0]      r_mult;
    logic [N-1:0][W-1:0]      r_idx;
    logic [N-1:0]             r_fin;
    logic [WAIT_W-1:0]        r_wait;

    logic [address_width:0]   w_rows_clamped;
    logic [N-1:0]             w_valid;
    logic [N-1:0]             w_hs;
    logic [N-1:0]             w_last;
    logic [N-1:0]             w_zero;
    logic [N-1:0]             w_fin_next;
    logic                     w_last_row;

    assign w_rows_clamped = (row_count > ROWS_MAX) ? ROWS_MAX : row_count;
    assign w_last_row     = ({1'b0, r_addr} == (r_rows - (address_width + 1)'(1)));

    always_comb begin
        w_valid    = '0;
        w_hs       = '0;
        w_last     = '0;
        w_zero     = '0;
        w_fin_next = '0;
        for (int l = 0; l < N; l++) begin
            w_valid[l]    = (r_state == ST_ISSUE) && !r_fin[l];
            w_hs[l]       = w_valid[l] && I_am_ready[l];
            w_last[l]     = (r_idx[l] >= r_mult[l]);
            w_zero[l]     = (r_mult[l] == '0);
            // Includes lanes finishing on this very edge so the row can close
            // without an extra idle ISSUE cycle.
            w_fin_next[l] = r_fin[l] || (w_hs[l] && w_last[l]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_rows  <= '0;
            r_mult  <= '0;
            r_fin   <= '0;
            r_wait  <= '0;
            for (int l = 0; l < N; l++) begin
                r_idx[l] <= W'(1);
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rows <= w_rows_clamped;
                        r_mult <= no_of_multiples;
                        r_addr <= '0;
                        r_wait <= '0;
                        for (int l = 0; l < N; l++) begin
                            r_idx[l] <= W'(1);
                        end
                        r_state <= (w_rows_clamped == '0) ? ST_DONE : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_wait == WAIT_LAST) begin
                        r_wait  <= '0;
                        // Fresh flags for the new row; zero-chunk lanes start finished.
                        r_fin   <= w_zero;
                        r_state <= ST_ISSUE;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                ST_ISSUE: begin
                    for (int l = 0; l < N; l++) begin
                        if (w_hs[l] && !w_last[l]) begin
                            r_idx[l] <= r_idx[l] + W'(1);
                        end
                    end
                    r_fin <= w_fin_next;
                    if (&w_fin_next) begin
                        r_state <= ST_ROW_END;
                    end
                end
                ST_ROW_END: begin
                    if (w_last_row) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_addr <= r_addr + address_width'(1);
                        for (int l = 0; l < N; l++) begin
                            r_idx[l] <= W'(1);
                        end
                        r_state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign memA_read_address = r_addr;
    assign chunk_index       = r_idx;
    assign chunk_valid       = w_valid;
    assign row_done          = (r_state == ST_ROW_END);
    assign busy              = (r_state != ST_IDLE);
    assign done              = (r_state == ST_DONE);

endmodule

// File: tb/tb_mema_chunk_scheduler.sv
// tb/tb_mema_chunk_scheduler.sv - self-checking bench for mema_chunk_scheduler
module tb_mema_chunk_scheduler;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int H   = 2000;
    localparam int AW  = $clog2(H) + 1;
    localparam int LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [AW:0]       row_count;
    logic [W*N-1:0]    no_of_multiples;
    logic [N-1:0]      I_am_ready;
    logic [AW-1:0]     memA_read_address;
    logic [W*N-1:0]    chunk_index;
    logic [N-1:0]      chunk_valid;
    logic              row_done;
    logic              busy;
    logic              done;

    mema_chunk_scheduler #(
        .no_of_row_by_vector_modules (N),
        .memory_A_height             (H),
        .multiples_memory_value_width(W),
        .read_latency                (LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .row_count        (row_count),
        .no_of_multiples  (no_of_multiples),
        .I_am_ready       (I_am_ready),
        .memA_read_address(memA_read_address),
        .chunk_index      (chunk_index),
        .chunk_valid      (chunk_valid),
        .row_done         (row_done),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;
    bit cmp_en = 1'b0;
    int rdy_mode = 0;

    int rd_q[$];
    int done_q[$];
    int hs[N];
    bit valid_seen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready pattern: all ready, or lane 2 toggling every cycle.
    initial begin
        I_am_ready = '1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) I_am_ready = {1'b1, cyc[0], 2'b11};
            else               I_am_ready = '1;
        end
    end

    // ---------------- behavioural model ----------------
    logic [AW-1:0] e_addr;
    int unsigned   e_idx[N];
    logic [N-1:0]  e_valid;
    logic          e_rd, e_busy, e_done;
    int            m_rows;
    int unsigned   m_mult[N];
    int unsigned   m_del[N];
    bit            m_abort;

    task m_idle();
        e_addr = '0;
        for (int l = 0; l < N; l++) e_idx[l] = 1;
        e_valid = '0;
        e_rd = 0; e_busy = 0; e_done = 0;
    endtask

    task m_step();
        @(posedge clk);
        if (rst) begin
            m_abort = 1;
            m_idle();
        end
    endtask

    function automatic bit all_delivered();
        for (int l = 0; l < N; l++) if (m_del[l] < m_mult[l]) return 0;
        return 1;
    endfunction

    task m_lane_view();
        for (int l = 0; l < N; l++) begin
            e_valid[l] = (m_del[l] < m_mult[l]);
            if (e_valid[l])          e_idx[l] = m_del[l] + 1;
            else if (m_mult[l] == 0) e_idx[l] = 1;
            else                     e_idx[l] = m_mult[l];
        end
    endtask

    initial begin
        int rc;
        m_idle();
        forever begin
            @(posedge clk);
            if (rst) begin
                m_idle();
                continue;
            end
            if (!start) continue;
            rc = int'(row_count);
            m_rows = (rc > H + 1) ? H + 1 : rc;
            for (int l = 0; l < N; l++) m_mult[l] = no_of_multiples[l*W +: W];
            m_abort = 0;
            e_busy = 1;
            e_addr = '0;
            for (int l = 0; l < N; l++) e_idx[l] = 1;
            for (int r = 0; r < m_rows; r++) begin
                e_addr = AW'(r);
                for (int l = 0; l < N; l++) e_idx[l] = 1;
                e_valid = '0;
                for (int w = 0; w < LAT; w++) begin
                    m_step();
                    if (m_abort) break;
                end
                if (m_abort) break;
                for (int l = 0; l < N; l++) m_del[l] = 0;
                do begin
                    m_lane_view();
                    m_step();
                    if (m_abort) break;
                    for (int l = 0; l < N; l++)
                        if (e_valid[l] && I_am_ready[l]) m_del[l]++;
                end while (!all_delivered());
                if (m_abort) break;
                m_lane_view();
                e_rd = 1;
                m_step();
                if (m_abort) break;
                e_rd = 0;
            end
            if (!m_abort) begin
                e_done = 1;
                m_step();
                if (!m_abort) begin
                    e_done = 0;
                    e_busy = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("addr", memA_read_address, e_addr);
            for (int l = 0; l < N; l++) begin
                chk($sformatf("idx%0d", l), chunk_index[l*W +: W], e_idx[l]);
                chk($sformatf("valid%0d", l), chunk_valid[l], e_valid[l]);
                if (chunk_valid[l] && I_am_ready[l]) hs[l]++;
            end
            chk("row_done", row_done, e_rd);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            if (|chunk_valid) valid_seen = 1;
            if (row_done) rd_q.push_back(cyc - t0);
            if (done) done_q.push_back(cyc - t0);
        end
    end

    // ---------------- stimulus ----------------
    task tick();
        @(posedge clk);
        #1;
    endtask

    task pulse_start(input int rc, input logic [W*N-1:0] mult);
        rd_q.delete();
        done_q.delete();
        for (int l = 0; l < N; l++) hs[l] = 0;
        valid_seen = 0;
        row_count = (AW+1)'(rc);
        no_of_multiples = mult;
        start = 1;
        t0 = cyc;
        tick();
        start = 0;
    endtask

    task wait_done(input int bound);
        int n;
        n = 0;
        while (done_q.size() == 0 && n < bound) begin
            tick();
            n++;
        end
        chk("done_timeout", done_q.size() > 0, 1);
        tick();
        tick();
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    initial begin
        bit found;
        rst = 1; start = 0; row_count = '0; no_of_multiples = '0;
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1;
        rst = 0;

        // Reset / idle state
        repeat (5) tick();
        chk("rst_addr", memA_read_address, 0);
        chk("rst_idx0", chunk_index[W-1:0], 1);
        chk("rst_idx3", chunk_index[4*W-1 -: W], 1);
        chk("rst_valid", chunk_valid, 0);
        chk("rst_busy", busy, 0);

        // One row, lanes 3..0 = 3,2,1,4
        pulse_start(1, {32'd3, 32'd2, 32'd1, 32'd4});
        wait_done(100);
        chk("t2_rd_k", q_at(rd_q, 0), 7);
        chk("t2_done_k", q_at(done_q, 0), 8);
        chk("t2_hs0", hs[0], 4);
        chk("t2_hs1", hs[1], 1);
        chk("t2_hs2", hs[2], 2);
        chk("t2_hs3", hs[3], 3);

        // Three rows, lane 2 ready toggling
        rdy_mode = 1;
        pulse_start(3, {32'd2, 32'd2, 32'd2, 32'd2});
        wait_done(200);
        rdy_mode = 0;
        chk("t3_rd_cnt", rd_q.size(), 3);
        chk("t3_done_cnt", done_q.size(), 1);
        chk("t3_hs2", hs[2], 6);

        // All-zero multiples
        pulse_start(2, '0);
        wait_done(100);
        chk("t4_valid_seen", valid_seen, 0);
        chk("t4_rd0_k", q_at(rd_q, 0), 4);
        chk("t4_rd1_k", q_at(rd_q, 1), 8);
        chk("t4_done_k", q_at(done_q, 0), 9);

        // Mid-pass reset at address 1, lane 0 index 2
        pulse_start(3, {32'd3, 32'd3, 32'd3, 32'd3});
        found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (memA_read_address == 1 && chunk_index[W-1:0] == 2) found = 1;
        end
        chk("t5_reached", found, 1);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        chk("t5_addr", memA_read_address, 0);
        chk("t5_idx0", chunk_index[W-1:0], 1);
        chk("t5_busy", busy, 0);
        repeat (4) tick();
        chk("t5_no_done", done_q.size(), 0);
        pulse_start(1, {32'd1, 32'd1, 32'd1, 32'd1});
        wait_done(100);
        chk("t5_restart_done_k", q_at(done_q, 0), 5);

        // Re-start while busy is ignored
        pulse_start(2, {32'd1, 32'd1, 32'd1, 32'd1});
        tick();
        start = 1;
        row_count = (AW+1)'(7);
        tick();
        start = 0;
        wait_done(100);
        chk("t6_rd_cnt", rd_q.size(), 2);
        chk("t6_done_k", q_at(done_q, 0), 9);

        // row_count = 0
        pulse_start(0, {32'd1, 32'd1, 32'd1, 32'd1});
        wait_done(50);
        chk("t6_zero_done_k", q_at(done_q, 0), 1);
        chk("t6_zero_rd_cnt", rd_q.size(), 0);

        // Oversized row_count clamps to H+1 rows
        pulse_start(8191, '0);
        wait_done(10000);
        chk("clamp_rd_cnt", rd_q.size(), H + 1);
        chk("clamp_done_k", q_at(done_q, 0), (H + 1) * 4 + 1);
        chk("clamp_last_addr", memA_read_address, H);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
